// File: rtl/jesd204_rx_align_pkg.sv
// Shared constants, state encoding and bit-vector helpers for the JESD204 RX
// frame/multiframe alignment monitor.
package jesd204_rx_align_pkg;

  localparam logic [7:0] K28_3_A = 8'h7C;
  localparam logic [7:0] K28_7_F = 8'hFC;

  typedef enum logic [1:0] {
    ALIGNED = 2'd0,
    SUSPECT = 2'd1,
    REALIGN = 2'd2
  } align_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [2:0] lowest_idx8(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/jesd204_rx_align_char_classify.sv
// Stage-1 per-octet classifier: flags misplaced /A/ and /F/ characters and
// correctly placed ones against the local eof/eomf markers.
module jesd204_rx_align_char_classify #(
  parameter int DATA_PATH_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         i_valid,
  input  logic                         i_mask,
  input  logic [8*DATA_PATH_WIDTH-1:0] i_data,
  input  logic [DATA_PATH_WIDTH-1:0]   i_charisk,
  input  logic [DATA_PATH_WIDTH-1:0]   i_eof,
  input  logic [DATA_PATH_WIDTH-1:0]   i_eomf,
  output logic                         o_valid,
  output logic [DATA_PATH_WIDTH-1:0]   o_bad_a,
  output logic [DATA_PATH_WIDTH-1:0]   o_bad_f,
  output logic [DATA_PATH_WIDTH-1:0]   o_good
);
  import jesd204_rx_align_pkg::*;

  logic [DATA_PATH_WIDTH-1:0] w_is_a;
  logic [DATA_PATH_WIDTH-1:0] w_is_f;
  logic [DATA_PATH_WIDTH-1:0] w_bad_a;
  logic [DATA_PATH_WIDTH-1:0] w_bad_f;
  logic [DATA_PATH_WIDTH-1:0] w_good;
  logic                       w_en;

  assign w_en = i_valid & ~i_mask;

  genvar g;
  generate
    for (g = 0; g < DATA_PATH_WIDTH; g++) begin : g_octet
      assign w_is_a[g]  = i_charisk[g] & (i_data[8*g +: 8] == K28_3_A);
      assign w_is_f[g]  = i_charisk[g] & (i_data[8*g +: 8] == K28_7_F);
      // An /F/ on the multiframe boundary is misplaced: only /A/ may sit there.
      assign w_bad_a[g] = w_is_a[g] & ~i_eomf[g];
      assign w_bad_f[g] = w_is_f[g] & (~i_eof[g] | i_eomf[g]);
      assign w_good[g]  = (w_is_a[g] & i_eomf[g]) | (w_is_f[g] & i_eof[g] & ~i_eomf[g]);
    end
  endgenerate

  // Register the classification; idle or masked beats produce empty vectors.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      o_valid <= 1'b0;
      o_bad_a <= {DATA_PATH_WIDTH{1'b0}};
      o_bad_f <= {DATA_PATH_WIDTH{1'b0}};
      o_good  <= {DATA_PATH_WIDTH{1'b0}};
    end else if (w_en) begin
      o_valid <= 1'b1;
      o_bad_a <= w_bad_a;
      o_bad_f <= w_bad_f;
      o_good  <= w_good;
    end else begin
      o_valid <= 1'b0;
      o_bad_a <= {DATA_PATH_WIDTH{1'b0}};
      o_bad_f <= {DATA_PATH_WIDTH{1'b0}};
      o_good  <= {DATA_PATH_WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/jesd204_rx_frame_align_monitor.sv
// Per-lane RX /F/ and /A/ alignment monitor with realignment request.
// Optional saturating error counter enabled by JESD204_RX_ALIGN_ERR_CNT_EN.
module jesd204_rx_frame_align_monitor #(
  parameter  int DATA_PATH_WIDTH = 4,
  localparam int POS_WIDTH       = $clog2(DATA_PATH_WIDTH)
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         cfg_disable_char_replacement,
  input  logic                         in_valid,
  input  logic [8*DATA_PATH_WIDTH-1:0] in_data,
  input  logic [DATA_PATH_WIDTH-1:0]   in_charisk,
  input  logic [DATA_PATH_WIDTH-1:0]   eof,
  input  logic [DATA_PATH_WIDTH-1:0]   eomf,
  input  logic                         realign_ack,
  output logic                         frame_align_err,
  output logic                         mframe_align_err,
  output logic                         realign_req,
  output logic [POS_WIDTH-1:0]         realign_pos,
  output logic [15:0]                  align_err_cnt
);
  import jesd204_rx_align_pkg::*;

  logic                       w_s1_valid;
  logic [DATA_PATH_WIDTH-1:0] w_bad_a;
  logic [DATA_PATH_WIDTH-1:0] w_bad_f;
  logic [DATA_PATH_WIDTH-1:0] w_good;
  logic [DATA_PATH_WIDTH-1:0] w_bad;
  logic [7:0]                 w_bad_ext;
  logic                       w_mis;
  logic                       w_any_good;
  logic [POS_WIDTH-1:0]       w_mis_pos;

  align_state_e               r_state;
  logic [POS_WIDTH-1:0]       r_last_pos;
  logic                       r_frame_err;
  logic                       r_mframe_err;
  logic                       r_req;
  logic [POS_WIDTH-1:0]       r_pos;

  jesd204_rx_align_char_classify #(
    .DATA_PATH_WIDTH (DATA_PATH_WIDTH)
  ) u_classify (
    .clk       (clk),
    .resetn    (resetn),
    .i_valid   (in_valid),
    .i_mask    (cfg_disable_char_replacement),
    .i_data    (in_data),
    .i_charisk (in_charisk),
    .i_eof     (eof),
    .i_eomf    (eomf),
    .o_valid   (w_s1_valid),
    .o_bad_a   (w_bad_a),
    .o_bad_f   (w_bad_f),
    .o_good    (w_good)
  );

  assign w_bad      = w_bad_a | w_bad_f;
  assign w_bad_ext  = 8'(w_bad);
  assign w_mis      = w_s1_valid & (|w_bad);
  assign w_any_good = w_s1_valid & (|w_good);
  assign w_mis_pos  = POS_WIDTH'(lowest_idx8(w_bad_ext));

  // Stage 2: alignment FSM and registered error/request outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ALIGNED;
      r_last_pos   <= {POS_WIDTH{1'b0}};
      r_frame_err  <= 1'b0;
      r_mframe_err <= 1'b0;
      r_req        <= 1'b0;
      r_pos        <= {POS_WIDTH{1'b0}};
    end else if (cfg_disable_char_replacement) begin
      r_state      <= ALIGNED;
      r_frame_err  <= 1'b0;
      r_mframe_err <= 1'b0;
      r_req        <= 1'b0;
    end else begin
      r_frame_err  <= w_s1_valid & (|w_bad_f);
      r_mframe_err <= w_s1_valid & (|w_bad_a);
      case (r_state)
        ALIGNED: begin
          if (w_mis) begin
            r_state    <= SUSPECT;
            r_last_pos <= w_mis_pos;
          end else begin
            r_state <= ALIGNED;
          end
        end
        SUSPECT: begin
          // A misplaced character outranks a good one in the same beat.
          if (w_mis && (w_mis_pos == r_last_pos)) begin
            r_state <= REALIGN;
            r_pos   <= w_mis_pos;
            r_req   <= 1'b1;
          end else if (w_mis) begin
            r_state    <= SUSPECT;
            r_last_pos <= w_mis_pos;
          end else if (w_any_good) begin
            r_state <= ALIGNED;
          end else begin
            r_state <= SUSPECT;
          end
        end
        REALIGN: begin
          if (realign_ack) begin
            r_state <= ALIGNED;
            r_req   <= 1'b0;
          end else begin
            r_state <= REALIGN;
            r_req   <= 1'b1;
          end
        end
        default: begin
          r_state <= ALIGNED;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign frame_align_err  = r_frame_err;
  assign mframe_align_err = r_mframe_err;
  assign realign_req      = r_req;
  assign realign_pos      = r_pos;

`ifdef JESD204_RX_ALIGN_ERR_CNT_EN
  logic [15:0] r_err_cnt;
  logic [16:0] w_cnt_sum;

  assign w_cnt_sum = {1'b0, r_err_cnt} + 17'(popcount8(w_bad_ext));

  // Saturating count of misplaced characters, one per offending octet.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err_cnt <= 16'h0000;
    end else if (cfg_disable_char_replacement) begin
      r_err_cnt <= 16'h0000;
    end else if (w_cnt_sum[16]) begin
      r_err_cnt <= 16'hFFFF;
    end else begin
      r_err_cnt <= w_cnt_sum[15:0];
    end
  end

  assign align_err_cnt = r_err_cnt;
`else
  assign align_err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_jesd204_rx_frame_align_monitor.sv
// Table-driven bench for jesd204_rx_frame_align_monitor (DATA_PATH_WIDTH=4),
// plus hand-written latency, reset, disable and counter sequences.
module tb_jesd204_rx_frame_align_monitor;

`ifdef JESD204_RX_ALIGN_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        cfg_dis;
  logic        in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_charisk;
  logic [3:0]  eof;
  logic [3:0]  eomf;
  logic        realign_ack;
  logic        frame_align_err;
  logic        mframe_align_err;
  logic        realign_req;
  logic [1:0]  realign_pos;
  logic [15:0] align_err_cnt;

  int checks;
  int errors;
  int model_cnt;

  typedef struct {
    logic        valid;
    logic        ack;
    logic [31:0] data;
    logic [3:0]  k;
    logic [3:0]  eof;
    logic [3:0]  eomf;
    logic        ferr;
    logic        aerr;
    logic        req;
    logic [1:0]  pos;
    int          nbad;
  } vec_t;

  vec_t tbl[$];

  jesd204_rx_frame_align_monitor #(
    .DATA_PATH_WIDTH (4)
  ) dut (
    .clk                          (clk),
    .resetn                       (resetn),
    .cfg_disable_char_replacement (cfg_dis),
    .in_valid                     (in_valid),
    .in_data                      (in_data),
    .in_charisk                   (in_charisk),
    .eof                          (eof),
    .eomf                         (eomf),
    .realign_ack                  (realign_ack),
    .frame_align_err              (frame_align_err),
    .mframe_align_err             (mframe_align_err),
    .realign_req                  (realign_req),
    .realign_pos                  (realign_pos),
    .align_err_cnt                (align_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic a, input logic [31:0] d,
                              input logic [3:0] k, input logic [3:0] ef, input logic [3:0] em,
                              input logic fe, input logic ae, input logic rq,
                              input logic [1:0] p, input int nb);
    vec_t r;
    r.valid = v; r.ack = a; r.data = d; r.k = k; r.eof = ef; r.eomf = em;
    r.ferr = fe; r.aerr = ae; r.req = rq; r.pos = p; r.nbad = nb;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic add_bad(input int n);
    if (CNT_EN) begin
      model_cnt = model_cnt + n;
      if (model_cnt > 65535) model_cnt = 65535;
    end
  endtask

  task automatic go_idle();
    in_valid = 1'b0; realign_ack = 1'b0; in_data = 32'h0;
    in_charisk = 4'h0; eof = 4'h0; eomf = 4'h0;
  endtask

  // Called at a negedge; returns at the negedge after the beat's outputs settle.
  task automatic apply_beat(input logic v, input logic a, input logic [31:0] d,
                            input logic [3:0] k, input logic [3:0] ef, input logic [3:0] em);
    in_valid = v; realign_ack = a; in_data = d; in_charisk = k; eof = ef; eomf = em;
    @(posedge clk);
    @(negedge clk);
    go_idle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_outs(input string tag, input logic fe, input logic ae,
                          input logic rq, input logic [1:0] p);
    chk({tag, "_ferr"}, 32'(frame_align_err), 32'(fe));
    chk({tag, "_aerr"}, 32'(mframe_align_err), 32'(ae));
    chk({tag, "_req"},  32'(realign_req), 32'(rq));
    chk({tag, "_pos"},  32'(realign_pos), 32'(p));
    chk({tag, "_cnt"},  32'(align_err_cnt), 32'(model_cnt));
  endtask

  initial begin
    checks = 0; errors = 0; model_cnt = 0;
    resetn = 1'b0; cfg_dis = 1'b0;
    go_idle();

    // Legal multiframe: /F/ at octet 3 on beats 0..6, /A/ at octet 3 on beat 7.
    for (int b = 0; b < 8; b++) begin
      if (b == 7) tbl.push_back(mk(1'b1, 1'b0, 32'h7C000000, 4'b1000, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0, 2'd0, 0));
      else        tbl.push_back(mk(1'b1, 1'b0, 32'hFC000000, 4'b1000, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 0));
    end
    tbl.push_back(mk(1'b1, 1'b0, 32'h00FC0000, 4'b0100, 4'b1010, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1)); // /F/ oct2 -> SUSPECT
    tbl.push_back(mk(1'b1, 1'b0, 32'hFC000000, 4'b1000, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 0)); // good -> ALIGNED
    tbl.push_back(mk(1'b1, 1'b0, 32'h00007C00, 4'b0010, 4'b1010, 4'b1000, 1'b0, 1'b1, 1'b0, 2'd0, 1)); // /A/ oct1
    tbl.push_back(mk(1'b1, 1'b0, 32'h00007C00, 4'b0010, 4'b1010, 4'b1000, 1'b0, 1'b1, 1'b1, 2'd1, 1)); // /A/ oct1 -> REALIGN
    tbl.push_back(mk(1'b1, 1'b0, 32'h000000FC, 4'b0001, 4'b1010, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 1)); // pulse in REALIGN
    tbl.push_back(mk(1'b0, 1'b1, 32'h00000000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 0)); // ack
    tbl.push_back(mk(1'b1, 1'b1, 32'h000000FC, 4'b0001, 4'b1010, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 1)); // stray ack, oct0
    tbl.push_back(mk(1'b1, 1'b0, 32'h00FC0000, 4'b0100, 4'b1010, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 1)); // oct2
    tbl.push_back(mk(1'b1, 1'b0, 32'h00FC0000, 4'b0100, 4'b1010, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 1)); // oct2 -> REALIGN
    tbl.push_back(mk(1'b0, 1'b1, 32'h00000000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 0)); // ack
    tbl.push_back(mk(1'b1, 1'b0, 32'hFC0000FC, 4'b1001, 4'b1010, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 1)); // good+bad: bad wins
    tbl.push_back(mk(1'b1, 1'b0, 32'hFC0000FC, 4'b1001, 4'b1010, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 1)); // -> REALIGN pos0
    tbl.push_back(mk(1'b0, 1'b1, 32'h00000000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 0)); // ack
    tbl.push_back(mk(1'b1, 1'b0, 32'h0000BC00, 4'b0010, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 0)); // K28.5 ignored
    tbl.push_back(mk(1'b1, 1'b0, 32'hFC000000, 4'b1000, 4'b1010, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd0, 1)); // /F/ on eomf
    tbl.push_back(mk(1'b1, 1'b0, 32'h7C000000, 4'b1000, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0, 2'd0, 0)); // good /A/ -> ALIGNED
    tbl.push_back(mk(1'b1, 1'b0, 32'hFC000000, 4'b1000, 4'b1010, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd0, 1)); // SUSPECT again
    tbl.push_back(mk(1'b1, 1'b0, 32'hFC000000, 4'b1000, 4'b1010, 4'b1000, 1'b1, 1'b0, 1'b1, 2'd3, 1)); // -> REALIGN pos3
    tbl.push_back(mk(1'b0, 1'b1, 32'h00000000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 0)); // ack
    tbl.push_back(mk(1'b1, 1'b0, 32'hFC000000, 4'b0000, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 0)); // 0xFC as data
    tbl.push_back(mk(1'b0, 1'b0, 32'h000000FC, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 0)); // invalid beat

    #1;
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 2'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      apply_beat(tbl[i].valid, tbl[i].ack, tbl[i].data, tbl[i].k, tbl[i].eof, tbl[i].eomf);
      add_bad(tbl[i].nbad);
      chk_outs($sformatf("v%0d", i), tbl[i].ferr, tbl[i].aerr, tbl[i].req, tbl[i].pos);
    end

    // Exact two-cycle latency of the error pulse (octet 1 /F/ without eof).
    in_valid = 1'b1; in_data = 32'h0000FC00; in_charisk = 4'b0010; eof = 4'b1000; eomf = 4'b0000;
    @(posedge clk); #1;
    chk("lat_c1", 32'(frame_align_err), 32'd0);
    go_idle();
    @(posedge clk); #1;
    chk("lat_c2", 32'(frame_align_err), 32'd1);
    add_bad(1);
    @(posedge clk); #1;
    chk("lat_c3", 32'(frame_align_err), 32'd0);
    @(negedge clk);
    apply_beat(1'b1, 1'b0, 32'h0000FC00, 4'b0010, 4'b1000, 4'b0000);
    add_bad(1);
    chk_outs("pre_rst", 1'b1, 1'b0, 1'b1, 2'd1);

    // Asynchronous reset while the request is up.
    #2 resetn = 1'b0;
    #1;
    model_cnt = 0;
    chk_outs("async_rst", 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Disable mid-REALIGN drops the request without an ack.
    apply_beat(1'b1, 1'b0, 32'h0000FC00, 4'b0010, 4'b1000, 4'b0000);
    apply_beat(1'b1, 1'b0, 32'h0000FC00, 4'b0010, 4'b1000, 4'b0000);
    add_bad(2);
    chk_outs("pre_dis", 1'b1, 1'b0, 1'b1, 2'd1);
    cfg_dis = 1'b1;
    @(posedge clk); #1;
    model_cnt = 0;
    chk("dis_req", 32'(realign_req), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      apply_beat(1'b1, 1'b0, 32'h00FC0000, 4'b0100, 4'b1010, 4'b0000);
      chk_outs($sformatf("dis%0d", i), 1'b0, 1'b0, 1'b0, 2'd1);
    end
    cfg_dis = 1'b0;
    apply_beat(1'b1, 1'b0, 32'h7C000000, 4'b1000, 4'b1010, 4'b1000);
    chk_outs("en_again", 1'b0, 1'b0, 1'b0, 2'd1);

`ifdef JESD204_RX_ALIGN_ERR_CNT_EN
    apply_beat(1'b1, 1'b0, 32'hFCFCFCFC, 4'b1111, 4'b0000, 4'b0000);
    add_bad(4);
    chk("cnt_plus4", 32'(align_err_cnt), 32'(model_cnt));
    resetn = 1'b0;
    #1;
    model_cnt = 0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'hFCFCFCFC; in_charisk = 4'b1111; eof = 4'b0000; eomf = 4'b0000;
    repeat (16383) @(negedge clk);
    go_idle();
    repeat (2) @(negedge clk);
    add_bad(16383 * 4);
    chk("cnt_65532", 32'(align_err_cnt), 32'd65532);
    apply_beat(1'b1, 1'b0, 32'hFC00FC00, 4'b1010, 4'b0000, 4'b0000);
    add_bad(2);
    chk("cnt_fffe", 32'(align_err_cnt), 32'h0000FFFE);
    apply_beat(1'b1, 1'b0, 32'hFCFCFCFC, 4'b1111, 4'b0000, 4'b0000);
    add_bad(4);
    chk("cnt_sat", 32'(align_err_cnt), 32'h0000FFFF);
    apply_beat(1'b1, 1'b0, 32'hFCFCFCFC, 4'b1111, 4'b0000, 4'b0000);
    add_bad(4);
    chk("cnt_sat_hold", 32'(align_err_cnt), 32'(model_cnt));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jesd204_rx_frame_align_monitor.md
Name: jesd204_rx_frame_align_monitor

Overview:
- RX-side counterpart of the TX frame-mark/character-replacement path.
- Checks one lane's descrambled, 8b/10b-decoded octet stream for /F/ (K28.7, 0xFC) and /A/ (K28.3, 0x7C) alignment characters against the local sof/eof/eomf markers.
- Reports misplaced characters and raises a realignment request when two consecutive misplaced characters land on the same octet position.
- Sits per lane between the lane deframer and the RX control FSM.

Parameters:
- DATA_PATH_WIDTH, 4, octets per beat (power of 2: 4 or 8).
- POS_WIDTH, $clog2(DATA_PATH_WIDTH), octet-index width (localparam, not overridable).

Ports:
- clk  input  1  lane/device clock.
- resetn  input  1  asynchronous active-low reset.
- cfg_disable_char_replacement  input  1  1 = monitor inactive; state forced to ALIGNED.
- in_valid  input  1  beat qualifier; data phase only.
- in_data  input  8*DATA_PATH_WIDTH  decoded octets; octet i = bits [8i+7:8i].
- in_charisk  input  DATA_PATH_WIDTH  per-octet K flag.
- eof  input  DATA_PATH_WIDTH  end-of-frame marker per octet, from frame-mark generator.
- eomf  input  DATA_PATH_WIDTH  end-of-multiframe marker per octet.
- realign_ack  input  1  controller accepted realign request.
- frame_align_err  output  1  pulse: misplaced /F/ seen.
- mframe_align_err  output  1  pulse: misplaced /A/ seen.
- realign_req  output  1  level; held until acked.
- realign_pos  output  POS_WIDTH  octet index of confirmed new alignment.
- align_err_cnt  output  16  saturating error count (optional feature).

Behaviour:
- Reset (resetn low, async): all outputs 0; state ALIGNED; last_pos 0; counter 0. Synchronous deassertion is handled upstream.
- Stage 1 (registered) classifies each octet i on in_valid:
  - isA = charisk & data==0x7C; isF = charisk & data==0xFC.
  - badA = isA & ~eomf[i].
  - badF = isF & (~eof[i] | eomf[i]).
  - good = (isA & eomf[i]) | (isF & eof[i] & ~eomf[i]).
- Stage 2 (registered) updates state and outputs. Latency from input beat to error pulse = 2 cycles.
- Per beat:
  - mis = any badA|badF.
  - mis_pos = lowest index with badA|badF.
  - frame_align_err = |badF; mframe_align_err = |badA (one-cycle pulses).
- Other K characters (K28.5, K28.0, etc.) are ignored. in_valid low: no classification, state held.
- FSM:
  - ALIGNED: mis -> SUSPECT, last_pos <= mis_pos. Otherwise stay.
  - SUSPECT:
    - mis & mis_pos==last_pos -> REALIGN; realign_pos <= mis_pos; realign_req <= 1.
    - mis & mis_pos!=last_pos -> stay SUSPECT; last_pos <= mis_pos.
    - good (any) & ~mis -> ALIGNED.
    - Beat with neither -> stay.
  - REALIGN: realign_req held high; error pulses still generated; no state update from data. realign_ack -> ALIGNED, realign_req <= 0 next cycle.
- Simultaneous good and misplaced characters in one beat: misplaced wins.
- realign_ack while not in REALIGN: ignored.
- cfg_disable_char_replacement=1: classification masked; state forced ALIGNED next cycle; realign_req cleared; pulses 0. Mid-REALIGN assertion drops the request without an ack.
- Pulses are never generated from beats with in_valid=0 in stage 1.

Optional Feature:
- Macro: JESD204_RX_ALIGN_ERR_CNT_EN.
- Defined:
  - align_err_cnt increments by the popcount of (badA|badF) per beat (up to DATA_PATH_WIDTH).
  - Saturates at 0xFFFF.
  - Cleared by reset and by cfg_disable_char_replacement=1.
- Undefined: align_err_cnt tied to 0; no counter logic.

Decomposition:
- Shared package jesd204_rx_align_pkg:
  - K28_3_A = 8'h7C, K28_7_F = 8'hFC.
  - State enum {ALIGNED, SUSPECT, REALIGN}.
- One sub-module: jesd204_rx_align_char_classify.
  - Stage-1 per-octet classifier (badA/badF/good vectors).
  - Instantiated once; contains the generate loop over octets.

Test Plan (DATA_PATH_WIDTH=4, F=2, 32 octets/MF):
- Legal stream: eof=4'b1010 every beat, eomf=4'b1000 on beat 7 of 8; 0xFC/K at octet 3 on non-last beats, 0x7C/K at octet 3 on last beat -> no pulses, realign_req stays 0, align_err_cnt=0.
- Single misplaced /F/ at octet 2 (eof[2]=0) -> frame_align_err pulse exactly 2 cycles later; state SUSPECT; next beat with correct /F/ at octet 3 -> ALIGNED, no req.
- /A/ at octet 1 in two consecutive alignment beats -> mframe_align_err twice; realign_req=1 with realign_pos=1, held until realign_ack pulse, then 0 one cycle after ack.
- Misplaced chars at octet 0 then octet 2 then octet 2 -> realign_req only after the third, realign_pos=2.
- resetn low while realign_req=1 -> all outputs 0 immediately (async); cfg_disable_char_replacement=1 during misplaced stream -> no pulses, counter 0.
- With JESD204_RX_ALIGN_ERR_CNT_EN: beat with all 4 octets 0xFC/K and eof=0 -> counter +4; preset near 0xFFFE -> saturates at 0xFFFF.
